// File: rtl/mag_compare_seq_if.sv
// Operand/result handshake bundle for the sequential magnitude comparator.
interface mag_compare_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             l;
  logic             e;
  logic [CW-1:0]    cycles;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, g, l, e, cycles
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, g, l, e, cycles
  );
endinterface

// File: rtl/mag_compare_seq.sv
// Sequential MSB-first magnitude comparator producing one-hot g/l/e flags,
// DIGIT bits per cycle, with valid/ready handshakes on operands and result.
module mag_compare_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIGIT      = 4,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mag_compare_seq_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  // Flipping the sign bit maps two's complement onto offset binary, so
  // the scan itself is always an unsigned compare.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic             e_q, e_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             hit;
  logic             new_diff;

  // Current digit under comparison and whether a difference is already latched.
  assign a_dig    = DIGIT'(a_q >> (32'(idx_q) * DIGIT));
  assign b_dig    = DIGIT'(b_q >> (32'(idx_q) * DIGIT));
  assign hit      = g_q | l_q;
  assign new_diff = !hit && (a_dig != b_dig);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      e_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      l_q         <= l_d;
      e_q         <= e_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, digit scan and registered handshake decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
          b_d     = bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
          idx_d   = IW'(NDIG - 1);
          cnt_d   = '0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (!hit) begin
          g_d = (a_dig > b_dig);
          l_d = (a_dig < b_dig);
        end
        if ((EARLY_EXIT != 0) && new_diff) begin
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          e_d     = !hit && !new_diff;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.g         = g_q;
  assign bus.l         = l_q;
  assign bus.e         = e_q;
  assign bus.cycles    = cnt_q;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Self-checking bench for mag_compare_seq: three instances (16/4 early exit,
// 16/4 full scan, 8/8 single digit) checked against a scoreboard of modelled results.
module tb_mag_compare_seq;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] gle;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  mag_compare_seq_if #(.WIDTH(16), .DIGIT(4)) bus0 ();
  mag_compare_seq_if #(.WIDTH(16), .DIGIT(4)) bus1 ();
  mag_compare_seq_if #(.WIDTH(8),  .DIGIT(8)) bus2 ();

  mag_compare_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mag_compare_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mag_compare_seq #(.WIDTH(8),  .DIGIT(8), .EARLY_EXIT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: sign-extend and compare, find first differing digit.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic sm, input int w, input int d, input bit ee);
    exp_t r;
    logic signed [17:0] va, vb;
    int nd, k;
    if (w == 8) begin
      va = sm ? {{10{av[7]}}, av[7:0]} : {10'b0, av[7:0]};
      vb = sm ? {{10{bv[7]}}, bv[7:0]} : {10'b0, bv[7:0]};
    end else begin
      va = sm ? {{2{av[15]}}, av} : {2'b0, av};
      vb = sm ? {{2{bv[15]}}, bv} : {2'b0, bv};
    end
    r.gle = (va > vb) ? 3'b100 : ((va < vb) ? 3'b010 : 3'b001);
    nd = w / d;
    r.cyc = nd;
    if (ee) begin
      for (int j = 0; j < nd; j++) begin
        k = (nd - 1 - j) * d;
        if ((((av ^ bv) >> k) & ((16'd1 << d) - 16'd1)) != 16'd0) begin
          r.cyc = j + 1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [15:0] av,
                        input logic [15:0] bv, input logic sm);
    case (sel)
      1:       begin bus1.in_valid = v; bus1.a = av;      bus1.b = bv;      bus1.signed_mode = sm; end
      2:       begin bus2.in_valid = v; bus2.a = av[7:0]; bus2.b = bv[7:0]; bus2.signed_mode = sm; end
      default: begin bus0.in_valid = v; bus0.a = av;      bus0.b = bv;      bus0.signed_mode = sm; end
    endcase
  endtask

  function automatic logic ov(input int sel);
    case (sel)
      1:       return bus1.out_valid;
      2:       return bus2.out_valid;
      default: return bus0.out_valid;
    endcase
  endfunction

  function automatic logic [2:0] rd_gle(input int sel);
    case (sel)
      1:       return {bus1.g, bus1.l, bus1.e};
      2:       return {bus2.g, bus2.l, bus2.e};
      default: return {bus0.g, bus0.l, bus0.e};
    endcase
  endfunction

  function automatic int rd_cyc(input int sel);
    case (sel)
      1:       return 32'(bus1.cycles);
      2:       return 32'(bus2.cycles);
      default: return 32'(bus0.cycles);
    endcase
  endfunction

  // Issue one operand pair and wait (bounded) for the result; latency counted in cycles.
  task automatic xact(input int sel, input logic [15:0] av, input logic [15:0] bv, input logic sm,
                      output logic [2:0] gle, output int cyc, output int lat, output bit to);
    int n;
    @(negedge clk);
    set_in(sel, 1'b1, av, bv, sm);
    @(negedge clk);
    set_in(sel, 1'b0, 16'hxxxx, 16'hxxxx, sm);
    n = 1;
    while (!ov(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    to  = !ov(sel);
    lat = n - 1;
    gle = rd_gle(sel);
    cyc = rd_cyc(sel);
  endtask

  // One-hot flags whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid) begin
      total++;
      if ($countones({bus0.g, bus0.l, bus0.e}) != 1) begin
        bad++;
        $display("FAIL onehot0: gle=%b required one-hot", {bus0.g, bus0.l, bus0.e});
      end
    end
    if (rst_n && bus1.out_valid) begin
      total++;
      if ($countones({bus1.g, bus1.l, bus1.e}) != 1) begin
        bad++;
        $display("FAIL onehot1: gle=%b required one-hot", {bus1.g, bus1.l, bus1.e});
      end
    end
    if (rst_n && bus2.out_valid) begin
      total++;
      if ($countones({bus2.g, bus2.l, bus2.e}) != 1) begin
        bad++;
        $display("FAIL onehot2: gle=%b required one-hot", {bus2.g, bus2.l, bus2.e});
      end
    end
  end

  task automatic test_reset();
    #12;
    total++;
    if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_hs: in_ready/out_valid=%b required 10", {bus0.in_ready, bus0.out_valid});
    end
    total++;
    if ({bus0.g, bus0.l, bus0.e} !== 3'b000) begin
      bad++;
      $display("FAIL reset_gle: got %b required 000", {bus0.g, bus0.l, bus0.e});
    end
    total++;
    if (bus0.cycles !== 3'd0) begin
      bad++;
      $display("FAIL reset_cycles: got %0d required 0", bus0.cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_compare(input string name, input int sel, input logic [15:0] av,
                              input logic [15:0] bv, input logic sm);
    logic [2:0] gle;
    int cyc, lat;
    bit to;
    exp_t ex;
    if (sel == 2) sb.push_back(model(av, bv, sm, 8, 8, 1'b1));
    else          sb.push_back(model(av, bv, sm, 16, 4, sel == 0));
    xact(sel, av, bv, sm, gle, cyc, lat, to);
    ex = sb.pop_front();
    total++;
    if (to) begin
      bad++;
      $display("FAIL %s_timeout: out_valid=0 after 40 cycles required 1", name);
    end
    total++;
    if (gle !== ex.gle) begin
      bad++;
      $display("FAIL %s_gle: got %b required %b", name, gle, ex.gle);
    end
    total++;
    if (cyc !== ex.cyc) begin
      bad++;
      $display("FAIL %s_cycles: got %0d required %0d", name, cyc, ex.cyc);
    end
    total++;
    if (lat !== ex.cyc) begin
      bad++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, ex.cyc);
    end
  endtask

  task automatic test_equal();
    test_compare("eq_1234", 0, 16'h1234, 16'h1234, 1'b0);
    test_compare("eq_neg",  0, 16'h8001, 16'h8001, 1'b1);
    test_compare("eq_full", 1, 16'hABCD, 16'hABCD, 1'b0);
  endtask

  task automatic test_early_exit();
    test_compare("ee_unsigned", 0, 16'h9000, 16'h1FFF, 1'b0);
    test_compare("ee_signed",   0, 16'h9000, 16'h1FFF, 1'b1);
    test_compare("full_unsig",  1, 16'h9000, 16'h1FFF, 1'b0);
    test_compare("full_signed", 1, 16'h9000, 16'h1FFF, 1'b1);
    test_compare("ee_low",      0, 16'h1235, 16'h1234, 1'b0);
  endtask

  task automatic test_boundary();
    test_compare("min_max_s",  0, 16'h8000, 16'h7FFF, 1'b1);
    test_compare("min_max_u",  0, 16'h8000, 16'h7FFF, 1'b0);
    test_compare("neg1_vs_1",  0, 16'hFFFF, 16'h0001, 1'b1);
    test_compare("nd1_s",      2, 16'h0080, 16'h007F, 1'b1);
    test_compare("nd1_u",      2, 16'h0080, 16'h007F, 1'b0);
    test_compare("nd1_eq",     2, 16'h00C3, 16'h00C3, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [2:0] gle;
    int cyc, lat;
    bit to;
    exp_t ex;
    logic [7:0] obs;
    bus0.out_ready = 1'b0;
    sb.push_back(model(16'h0005, 16'h0003, 1'b0, 16, 4, 1'b1));
    xact(0, 16'h0005, 16'h0003, 1'b0, gle, cyc, lat, to);
    ex = sb.pop_front();
    total++;
    if (to || gle !== ex.gle || cyc !== ex.cyc) begin
      bad++;
      $display("FAIL bp_result: to=%0d gle=%b cyc=%0d required gle=%b cyc=%0d", to, gle, cyc, ex.gle, ex.cyc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) set_in(0, 1'b1, 16'hF000, 16'h0000, 1'b0);
      if (i == 4) set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      obs = {bus0.out_valid, bus0.in_ready, bus0.g, bus0.l, bus0.e, bus0.cycles};
      total++;
      if (obs !== {1'b1, 1'b0, ex.gle, 3'(ex.cyc)}) begin
        bad++;
        $display("FAIL bp_hold%0d: got %b required %b", i, obs, {1'b1, 1'b0, ex.gle, 3'(ex.cyc)});
      end
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: in_ready/out_valid=%b required 10", {bus0.in_ready, bus0.out_valid});
    end
    @(negedge clk);
    total++;
    if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_ignored: in_ready/out_valid=%b required 10", {bus0.in_ready, bus0.out_valid});
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    set_in(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus0.g, bus0.l, bus0.e, bus0.out_valid, bus0.in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL rst_mid: g,l,e,out_valid,in_ready=%b required 00001",
               {bus0.g, bus0.l, bus0.e, bus0.out_valid, bus0.in_ready});
    end
    total++;
    if (bus0.cycles !== 3'd0) begin
      bad++;
      $display("FAIL rst_mid_cycles: got %0d required 0", bus0.cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_compare("after_rst", 0, 16'h0001, 16'h0002, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] av, bv;
    logic sm;
    for (int i = 0; i < 50; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      sm = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bv = av;
      else if ($urandom_range(0, 3) == 0) bv = {av[15:4], bv[3:0]};
      test_compare($sformatf("b2b%0d", i), i % 2, av, bv, sm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_in(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_in(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    test_reset();
    test_equal();
    test_early_exit();
    test_boundary();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
